// File: rtl/i2s_rx_if.sv
// Receiver-side I2S bundle: the serial lines in, plus the left/right pair
// stream out to the capture side of the audio pipeline.
interface i2s_rx_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  sck_in;
  logic                  ws_in;
  logic                  sdi_in;
  logic                  ready_in;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] audio0_out;
  logic [DATA_WIDTH-1:0] audio1_out;

  // Receiver: consumes serial lines and ready, produces the pair stream.
  modport master (
    input  sck_in, ws_in, sdi_in, ready_in,
    output valid_out, audio0_out, audio1_out
  );

  // Environment: drives serial lines and ready, consumes the pair stream.
  modport slave (
    output sck_in, ws_in, sdi_in, ready_in,
    input  valid_out, audio0_out, audio1_out
  );
endinterface

// File: rtl/i2s_rx_unit.sv
// I2S serial receiver. sck/ws/sdi are oversampled by clk through identical
// synchronizer chains, rising sck edges are turned into one-clk strobes, and
// 24-bit MSB-first words with the standard one-bit WS delay are assembled
// into left/right pairs presented on a valid/ready interface.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | standby (reset or en_in low), datapath held cleared
//   ST_SYNC  | waiting for a WS transition to align to a word boundary
//   ST_RUN   | shifting bits, checking half-period length, building pairs
module i2s_rx_unit #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en_in,
  input  logic     clr_in,
  output logic     overrun_out,
  output logic     frame_err_out,
  i2s_rx_if.master bus
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sck_s;
  logic                   ws_s;
  logic                   sd_s;

  // Edge strobe and the ws/sd values captured with it, one register stage
  // after the synchronizers so all three stay aligned.
  logic                   sck_prev;
  logic                   edge_r;
  logic                   ws_k;
  logic                   sd_k;

  logic [1:0]             state;
  logic [DATA_WIDTH-1:0]  shift_r;
  logic [DATA_WIDTH-1:0]  left_r;
  logic [CW-1:0]          bit_cnt;
  logic                   have_left;
  logic                   ws_prev;
  // ws_prev only means something once an edge has been seen since enable;
  // without this, re-enabling mid-right-channel would fake a WS transition.
  logic                   ws_seen;

  logic                   valid_r;
  logic [DATA_WIDTH-1:0]  audio0_r;
  logic [DATA_WIDTH-1:0]  audio1_r;
  logic                   overrun_r;
  logic                   ferr_r;

  logic                   ws_chg;
  logic                   last_bit;
  logic [DATA_WIDTH-1:0]  word;
  logic                   run_edge;
  logic                   word_done;
  logic                   pair_done;
  logic                   ferr_set;
  logic                   load_out;
  logic                   ovr_set;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign ws_s  = ws_sync[SYNC_STAGES-1];
  assign sd_s  = sd_sync[SYNC_STAGES-1];

  // Identical synchronizer chains for the three asynchronous serial lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck_in};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0],  bus.ws_in};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0],  bus.sdi_in};
    end
  end

  // Rising sck detect; ws/sd are captured alongside the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_prev <= 1'b0;
      edge_r   <= 1'b0;
      ws_k     <= 1'b0;
      sd_k     <= 1'b0;
    end else begin
      sck_prev <= sck_s;
      edge_r   <= sck_s & ~sck_prev;
      ws_k     <= ws_s;
      sd_k     <= sd_s;
    end
  end

  assign ws_chg    = ws_seen && (ws_k != ws_prev);
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign word      = {shift_r[DATA_WIDTH-2:0], sd_k};
  assign run_edge  = en_in && (state == ST_RUN) && edge_r;
  assign word_done = run_edge && ws_chg && last_bit;
  // A completing word belongs to the channel that just ended (ws_prev).
  assign pair_done = word_done && ws_prev && have_left;
  assign ferr_set  = run_edge && (ws_chg != last_bit);
  assign load_out  = pair_done && (!valid_r || bus.ready_in);
  assign ovr_set   = pair_done && !load_out;

  // Framing FSM, deserializer and left-word holding register.
  always_ff @(posedge clk) begin
    if (rst || !en_in) begin
      state     <= ST_IDLE;
      shift_r   <= '0;
      left_r    <= '0;
      bit_cnt   <= '0;
      have_left <= 1'b0;
      ws_prev   <= 1'b0;
      ws_seen   <= 1'b0;
    end else begin
      if (edge_r) begin
        ws_prev <= ws_k;
        ws_seen <= 1'b1;
      end
      case (state)
        ST_IDLE: state <= ST_SYNC;
        ST_SYNC: begin
          if (edge_r && ws_chg) begin
            state     <= ST_RUN;
            bit_cnt   <= '0;
            have_left <= 1'b0;
          end
        end
        ST_RUN: begin
          if (edge_r) begin
            shift_r <= word;
            if (ws_chg) begin
              bit_cnt <= '0;
              if (!last_bit) begin
                have_left <= 1'b0;
              end else if (!ws_prev) begin
                left_r    <= word;
                have_left <= 1'b1;
              end else begin
                // Right word either completes the pair or has no partner.
                have_left <= 1'b0;
              end
            end else if (last_bit) begin
              // Half-period too long: drop alignment and look for WS again.
              state     <= ST_SYNC;
              bit_cnt   <= '0;
              have_left <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output pair register with single-entry valid/ready handshake.
  always_ff @(posedge clk) begin
    if (rst || !en_in) begin
      valid_r  <= 1'b0;
      audio0_r <= '0;
      audio1_r <= '0;
    end else if (load_out) begin
      valid_r  <= 1'b1;
      audio0_r <= left_r;
      audio1_r <= word;
    end else if (valid_r && bus.ready_in) begin
      valid_r <= 1'b0;
    end
  end

  // Sticky error flags; a set event wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_r <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      if (ovr_set)     overrun_r <= 1'b1;
      else if (clr_in) overrun_r <= 1'b0;
      if (ferr_set)    ferr_r    <= 1'b1;
      else if (clr_in) ferr_r    <= 1'b0;
    end
  end

  assign bus.valid_out  = valid_r;
  assign bus.audio0_out = audio0_r;
  assign bus.audio1_out = audio1_r;
  assign overrun_out    = overrun_r;
  assign frame_err_out  = ferr_r;

endmodule

// File: tb/tb_i2s_rx_unit.sv
// Bench for i2s_rx_unit: an I2S transmitter BFM sends half-periods of given
// channel/word/length, and a half-period-level model predicts pairs and flags.
module tb_i2s_rx_unit;
  localparam int DW = 24;
  localparam int SS = 2;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic clk = 1'b0;
  logic rst, en_in, clr_in;
  logic overrun_out, frame_err_out;

  i2s_rx_if #(.DATA_WIDTH(DW)) bus ();

  i2s_rx_unit #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk           (clk),
    .rst           (rst),
    .en_in         (en_in),
    .clr_in        (clr_in),
    .overrun_out   (overrun_out),
    .frame_err_out (frame_err_out),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  pair_t         exp_q[$];
  int            sess_idx;
  bit            prev_ch;
  logic [DW-1:0] prev_word;
  int            prev_n;
  bit            have_left_m;
  logic [DW-1:0] left_m;
  bit            exp_ferr, exp_ovr;
  bit            pending_bit;
  int unsigned   pair_rise_cyc;
  int            pairs_seen = 0;
  bit            lat_arm = 0;
  bit            standby = 0;
  bit            standby_hit = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sess_idx    = 0;
    have_left_m = 0;
    exp_q.delete();
  endtask

  // Called when a new half-period begins: the previous one is now finished.
  // Half 0 of a session has no WS transition in front of it and is discarded.
  task automatic model_boundary(output bit pushed);
    pair_t p;
    pushed = 0;
    if (sess_idx >= 2) begin
      if (prev_n != DW) begin
        exp_ferr    = 1;
        have_left_m = 0;
      end else if (!prev_ch) begin
        have_left_m = 1;
        left_m      = prev_word;
      end else if (have_left_m) begin
        have_left_m = 0;
        if (exp_q.size() > 0 && !bus.ready_in) exp_ovr = 1;
        else begin
          p.l = left_m;
          p.r = prev_word;
          exp_q.push_back(p);
          pushed = 1;
        end
      end
    end
  endtask

  // One SCK period; called and returns at posedge+1.
  task automatic sck_cycle(input bit ws, input bit sd, input int hi, input int lo, input bit mark);
    bus.sck_in = 1'b0;
    bus.ws_in  = ws;
    bus.sdi_in = sd;
    repeat (lo) @(posedge clk);
    #1;
    bus.sck_in = 1'b1;
    if (mark) pair_rise_cyc = cyc;
    repeat (hi) @(posedge clk);
    #1;
  endtask

  // One WS half-period of n SCK edges; the first edge carries the previous LSB.
  task automatic send_half(input bit ch, input logic [DW-1:0] w, input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      bit sd;
      bit pushed;
      pushed = 0;
      if (i == 0) begin
        model_boundary(pushed);
        sd = pending_bit;
      end else begin
        sd = (DW - i >= 0) ? w[DW-i] : 1'b0;
      end
      sck_cycle(ch, sd, hi, lo, pushed);
    end
    pending_bit = (DW - n >= 0) ? w[DW-n] : 1'b0;
    prev_ch   = ch;
    prev_word = w;
    prev_n    = n;
    sess_idx++;
  endtask

  task automatic restart(input bit check_clear);
    @(posedge clk); #1;
    en_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (check_clear) begin
      chk("dis_valid", bus.valid_out, 1'b0);
      chk("dis_audio0", bus.audio0_out, '0);
      chk("dis_audio1", bus.audio1_out, '0);
      chk("dis_overrun_held", overrun_out, exp_ovr);
      chk("dis_ferr_held", frame_err_out, exp_ferr);
    end
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    en_in = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_in = 1'b1;
    @(posedge clk); #1;
    clr_in   = 1'b0;
    exp_ovr  = 0;
    exp_ferr = 0;
    @(negedge clk);
    chk("clr_overrun", overrun_out, 1'b0);
    chk("clr_ferr", frame_err_out, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare process: pops the model on every handshake, checks hold stability.
  logic          prev_valid = 1'b0;
  bit            prev_hs = 0;
  logic [DW-1:0] prev_a0, prev_a1;
  pair_t         cp;
  bit            hs;
  always @(negedge clk) begin
    if (!rst) begin
      hs = bus.valid_out && bus.ready_in;
      if (standby && bus.valid_out) standby_hit = 1;
      if (prev_valid && !prev_hs && bus.valid_out) begin
        chk("hold_audio0", bus.audio0_out, prev_a0);
        chk("hold_audio1", bus.audio1_out, prev_a1);
      end
      if (lat_arm && bus.valid_out && !prev_valid) begin
        chk("latency", cyc - pair_rise_cyc, SS + 2);
        lat_arm = 0;
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pair: got 0x%0h/0x%0h expected none", bus.audio0_out, bus.audio1_out);
        end else begin
          cp = exp_q.pop_front();
          chk("pair_audio0", bus.audio0_out, cp.l);
          chk("pair_audio1", bus.audio1_out, cp.r);
          pairs_seen++;
        end
      end
      prev_valid = bus.valid_out;
      prev_hs    = hs;
      prev_a0    = bus.audio0_out;
      prev_a1    = bus.audio1_out;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [DW-1:0] nv;
    rst = 1'b1; en_in = 1'b0; clr_in = 1'b0;
    bus.sck_in = 1'b0; bus.ws_in = 1'b0; bus.sdi_in = 1'b0; bus.ready_in = 1'b1;
    exp_ferr = 0; exp_ovr = 0; pending_bit = 0;
    prev_ch = 0; prev_word = '0; prev_n = 0;
    model_reset();

    // Reset and standby
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.valid_out, 1'b0);
    chk("rst_audio0", bus.audio0_out, '0);
    chk("rst_audio1", bus.audio1_out, '0);
    chk("rst_overrun", overrun_out, 1'b0);
    chk("rst_ferr", frame_err_out, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    standby = 1;
    for (int i = 0; i < 80; i++) sck_cycle(1'($urandom), 1'($urandom), 1, 1, 0);
    standby = 0;
    chk("standby_no_valid", standby_hit, 1'b0);

    // Basic pair, 4/4 SCK, with latency measurement
    restart(0);
    bus.ready_in = 1'b0;
    lat_arm = 1;
    send_half(1, DW'($urandom), 24, 4, 4);
    send_half(0, 24'h800001, 24, 4, 4);
    send_half(1, 24'h7FFFFE, 24, 4, 4);
    send_half(0, DW'($urandom), 24, 4, 4);
    @(negedge clk);
    chk("basic_valid", bus.valid_out, 1'b1);
    chk("basic_audio0", bus.audio0_out, 24'h800001);
    chk("basic_audio1", bus.audio1_out, 24'h7FFFFE);
    chk("basic_model_q", exp_q.size(), 1);
    chk("basic_lat_done", lat_arm, 1'b0);
    @(posedge clk); #1;
    bus.ready_in = 1'b1;
    idle_clks(5);
    chk("basic_drained", exp_q.size(), 0);

    // Fast SCK, 10 frames
    restart(0);
    p0 = pairs_seen;
    send_half(1, DW'($urandom), int'($urandom_range(3, 30)), 1, 1);
    for (int n = 0; n < 10; n++) begin
      nv = DW'(n);
      send_half(0, nv, 24, 1, 1);
      send_half(1, ~nv, 24, 1, 1);
    end
    send_half(0, DW'($urandom), 24, 1, 1);
    idle_clks(10);
    chk("fast_pairs", pairs_seen - p0, 10);
    chk("fast_drained", exp_q.size(), 0);
    chk("fast_ferr", frame_err_out, 1'b0);
    chk("fast_overrun", overrun_out, 1'b0);

    // Backpressure
    restart(0);
    bus.ready_in = 1'b0;
    send_half(1, DW'($urandom), 10, 2, 2);
    for (int n = 0; n < 3; n++) begin
      send_half(0, DW'($urandom), 24, 2, 2);
      send_half(1, DW'($urandom), 24, 2, 2);
    end
    send_half(0, DW'($urandom), 24, 2, 2);
    @(negedge clk);
    chk("bp_model_ovr", exp_ovr, 1'b1);
    chk("bp_model_q", exp_q.size(), 1);
    chk("bp_valid", bus.valid_out, 1'b1);
    chk("bp_audio0", bus.audio0_out, exp_q[0].l);
    chk("bp_audio1", bus.audio1_out, exp_q[0].r);
    chk("bp_overrun", overrun_out, 1'b1);
    @(posedge clk); #1;
    pulse_clr();
    bus.ready_in = 1'b1;
    idle_clks(5);
    chk("bp_drained", exp_q.size(), 0);

    // Framing: short half-period
    restart(0);
    p0 = pairs_seen;
    send_half(1, DW'($urandom), 7, 2, 2);
    send_half(0, DW'($urandom), 24, 2, 2);
    send_half(1, DW'($urandom), 23, 2, 2);
    for (int n = 0; n < 2; n++) begin
      send_half(0, DW'($urandom), 24, 2, 2);
      send_half(1, DW'($urandom), 24, 2, 2);
    end
    send_half(0, DW'($urandom), 24, 2, 2);
    idle_clks(8);
    chk("short_model_ferr", exp_ferr, 1'b1);
    chk("short_ferr", frame_err_out, 1'b1);
    chk("short_pairs", pairs_seen - p0, 2);
    chk("short_drained", exp_q.size(), 0);
    pulse_clr();

    // Framing: long half-period
    restart(0);
    p0 = pairs_seen;
    send_half(1, DW'($urandom), 5, 2, 2);
    send_half(0, DW'($urandom), 24, 2, 2);
    send_half(1, DW'($urandom), 25, 2, 2);
    for (int n = 0; n < 2; n++) begin
      send_half(0, DW'($urandom), 24, 2, 2);
      send_half(1, DW'($urandom), 24, 2, 2);
    end
    send_half(0, DW'($urandom), 24, 2, 2);
    idle_clks(8);
    chk("long_ferr", frame_err_out, 1'b1);
    chk("long_pairs", pairs_seen - p0, 2);
    chk("long_drained", exp_q.size(), 0);
    pulse_clr();

    // Mid-frame disable at bit 12 of the right word
    restart(0);
    send_half(1, DW'($urandom), 9, 2, 2);
    send_half(0, DW'($urandom) | 24'h1, 24, 2, 2);
    send_half(1, DW'($urandom) | 24'h1, 24, 2, 2);
    send_half(0, DW'($urandom), 24, 2, 2);
    send_half(1, DW'($urandom), 13, 2, 2);
    chk("dis_prev_valid", bus.audio0_out != '0, 1'b1);
    restart(1);
    p0 = pairs_seen;
    send_half(0, DW'($urandom), 11, 2, 2);
    for (int n = 0; n < 2; n++) begin
      send_half(1, DW'($urandom), 24, 2, 2);
      send_half(0, DW'($urandom), 24, 2, 2);
    end
    send_half(1, DW'($urandom), 24, 2, 2);
    send_half(0, DW'($urandom), 24, 2, 2);
    idle_clks(8);
    chk("resume_pairs", pairs_seen - p0, 2);
    chk("resume_drained", exp_q.size(), 0);

    // Randomized lengths and SCK rates
    restart(0);
    send_half(1, DW'($urandom), int'($urandom_range(2, 30)), 1, 1);
    for (int n = 0; n < 16; n++) begin
      int k;
      int len;
      k = int'($urandom_range(0, 5));
      len = (k == 0) ? 23 : (k == 1) ? 25 : 24;
      send_half(1'(n), DW'($urandom), len, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
    end
    send_half(0, DW'($urandom), 24, 2, 2);
    idle_clks(8);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_ferr", frame_err_out, exp_ferr);
    chk("final_overrun", overrun_out, exp_ovr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
